// File: rtl/ru_pkg.sv
// Shared definitions for the Remote Update access scheduler:
// parameter codes, reason-bit positions, FSM states and the reconfig hold helper.
package ru_pkg;

  // Remote Update parameter select codes
  localparam logic [2:0] RU_P_CONFDONE = 3'b001;
  localparam logic [2:0] RU_P_WDOG_EN  = 3'b011;
  localparam logic [2:0] RU_P_BOOTADDR = 3'b100;
  localparam logic [2:0] RU_P_OSCINT   = 3'b110;
  localparam logic [2:0] RU_P_REASON   = 3'b111;

  // Bit positions inside the reconfiguration reason word
  localparam int RU_REASON_CRC = 3;

  // Data widths of the megafunction ports
  localparam int RU_WDATA_W = 22;
  localparam int RU_RDATA_W = 24;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE,
    ST_RECONF,
    ST_LOCKED
  } ru_state_t;

  // Cycles needed to cover a 250 ns reconfig pulse, rounded up
  function automatic int hold_cycles(input int clk_mhz);
    return (clk_mhz * 250 + 999) / 1000;
  endfunction

endpackage

// File: rtl/ru_access_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping around to the lowest index when nothing at or above ptr is set.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  int idx;

  // Scan requesters starting at ptr; the first set bit wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ru_access_scheduler.sv
// Shared-access scheduler for the Remote Update megafunction. Serialises
// parameter reads/writes from several requesters, waits out busy, returns
// read data, and drives a reconfig pulse that locks the block until reset.
module ru_access_scheduler
  import ru_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CLK_MHZ = 125,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [3*NUM_REQ-1:0]    req_param,
  input  logic [2*NUM_REQ-1:0]    req_source,
  input  logic [22*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    err,
  output logic [RU_RDATA_W-1:0]   rd_data,
  input  logic                    reconfig_req,
  output logic                    init_done,
  output logic                    reconfig_active,
  output logic                    ru_reset,
  output logic                    ru_write_param,
  output logic                    ru_read_param,
  output logic                    ru_reconfig,
  output logic [2:0]              ru_param,
  output logic [1:0]              ru_read_source,
  output logic [RU_WDATA_W-1:0]   ru_data_in,
  input  logic                    ru_busy,
  input  logic [RU_RDATA_W-1:0]   ru_data_out
);

  localparam int PW   = $clog2(NUM_REQ);
  localparam int HOLD = hold_cycles(CLK_MHZ);
  localparam int HW   = $clog2(HOLD + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD);
  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0]      IDX_LAST   = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  ru_state_t            state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        cur_idx;
  logic                 cur_write;
  logic                 init_seen;
  logic [TW-1:0]        timer;
  logic [HW-1:0]        hold_cnt;

  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 grant_valid;
  logic [PW-1:0]        grant_idx;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant_onehot),
    .valid (grant_valid)
  );

  // Convert the one-hot grant into an index for slicing the request buses
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        grant_idx = PW'(i);
      end
    end
  end

  // Main sequencer: every megafunction control and handshake output is registered here
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_INIT;
      rr_ptr          <= '0;
      cur_idx         <= '0;
      cur_write       <= 1'b0;
      init_seen       <= 1'b0;
      timer           <= '0;
      hold_cnt        <= '0;
      ack             <= '0;
      err             <= 1'b0;
      rd_data         <= '0;
      init_done       <= 1'b0;
      reconfig_active <= 1'b0;
      ru_reset        <= 1'b1;
      ru_write_param  <= 1'b0;
      ru_read_param   <= 1'b0;
      ru_reconfig     <= 1'b0;
      ru_param        <= '0;
      ru_read_source  <= '0;
      ru_data_in      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ru_reset  <= 1'b0;
          init_seen <= 1'b1;
          if (init_seen && !ru_busy) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end

        ST_IDLE: begin
          if (reconfig_req) begin
            state           <= ST_RECONF;
            ru_reconfig     <= 1'b1;
            reconfig_active <= 1'b1;
            hold_cnt        <= '0;
          end else if (grant_valid) begin
            cur_idx        <= grant_idx;
            cur_write      <= req_write[grant_idx];
            ru_param       <= req_param[3*grant_idx +: 3];
            ru_read_source <= req_source[2*grant_idx +: 2];
            ru_data_in     <= req_data[22*grant_idx +: 22];
            ru_write_param <= req_write[grant_idx];
            ru_read_param  <= !req_write[grant_idx];
            state          <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          ru_write_param <= 1'b0;
          ru_read_param  <= 1'b0;
          state          <= ST_SETTLE;
        end

        ST_SETTLE: begin
          timer <= '0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!ru_busy) begin
            state <= ST_DONE;
            ack   <= ONE_HOT0 << cur_idx;
            err   <= 1'b0;
            if (!cur_write) begin
              rd_data <= ru_data_out;
            end
          end else if (timer == TIMER_LAST) begin
            state <= ST_DONE;
            ack   <= ONE_HOT0 << cur_idx;
            err   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DONE: begin
          ack    <= '0;
          err    <= 1'b0;
          rr_ptr <= (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;
          state  <= ST_IDLE;
        end

        ST_RECONF: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_LOCKED;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_LOCKED: begin
          state <= ST_LOCKED;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/ru_access_scheduler.md
# ru_access_scheduler

Shared-access scheduler for the Remote Update megafunction in the bootloader. It lets several requesters each issue one parameter read or write at a time: the boot sequencer, the Ethernet-commanded reprogram path and the status/readback path. Arbitration is round-robin. The block generates the single-cycle `write_param`/`read_param` strobes, waits out `busy`, and returns read data. A reconfiguration request wins over pending operations and drives the `reconfig` line for the required minimum pulse.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, range 2..8.
- `CLK_MHZ`, default 125: clock frequency. `HOLD = ceil(CLK_MHZ*250/1000)` is the `reconfig` hold in cycles (more than 250 ns).
- `TIMEOUT`, default 4096: maximum cycles spent waiting for `busy` to fall.

Ports:
- `clock  in  1`: system clock.
- `reset  in  1`: synchronous, active-high.
- `req  in  NUM_REQ`: request level per requester. Held until that requester's `ack`.
- `req_write  in  NUM_REQ`: 1 = write, 0 = read.
- `req_param  in  3*NUM_REQ`: parameter code per requester (slice i = bits 3i+2:3i).
- `req_source  in  2*NUM_REQ`: read_source per requester.
- `req_data  in  22*NUM_REQ`: write data per requester.
- `ack  out  NUM_REQ`: one-cycle completion pulse.
- `err  out  1`: valid with `ack`. 1 = busy timeout.
- `rd_data  out  24`: captured `data_out`. Valid with `ack`, held until the next capture.
- `reconfig_req  in  1`: level request to reconfigure.
- `init_done  out  1`: megafunction reset complete.
- `reconfig_active  out  1`: high from reconfig start until reset.
- `ru_reset, ru_write_param, ru_read_param, ru_reconfig  out  1`: megafunction controls.
- `ru_param  out  3`: megafunction parameter select.
- `ru_read_source  out  2`: megafunction read source.
- `ru_data_in  out  22`: megafunction write data.
- `ru_busy  in  1`: megafunction busy.
- `ru_data_out  in  24`: megafunction read data.

## Operation
- States: INIT, IDLE, ISSUE, SETTLE, WAIT, DONE, RECONF, LOCKED.
- INIT:
  - `ru_reset`=1 for the first cycle, then 0.
  - Move to IDLE when `ru_busy`=0 and at least 2 cycles have elapsed in INIT.
  - Set `init_done`=1 on entry to IDLE; it stays 1 until `reset`.
- IDLE:
  - If `reconfig_req`, go to RECONF. This has priority over every `req`.
  - Otherwise, if any `req` is set, grant the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On grant, latch that requester's param, source, data and write flag into the `ru_*` output registers, then go to ISSUE.
- ISSUE: pulse `ru_write_param` or `ru_read_param` for exactly one cycle, then go to SETTLE.
- SETTLE: one dead cycle, because `busy` rises one cycle late. Then go to WAIT.
- WAIT:
  - Stay while `ru_busy`=1; the timer counts each cycle.
  - On `ru_busy`=0, go to DONE.
  - When the timer reaches `TIMEOUT`, go to DONE with the error flag set.
- DONE:
  - For a read without error, `rd_data <= ru_data_out`.
  - Pulse `ack[grant]` together with `err`.
  - Set `rr_ptr <= (grant+1) mod NUM_REQ`.
  - Return to IDLE.
- RECONF: `ru_reconfig`=1 and `reconfig_active`=1 for `HOLD+1` cycles, then go to LOCKED.
- LOCKED:
  - `ru_reconfig` stays 1 and no further grants are made.
  - A `req` arriving here is never acked.
  - Only `reset` exits this state.
- A `reconfig_req` that arrives mid-operation waits until the current operation's DONE; it is taken at the next IDLE.
- `req` dropped before `ack`: the latched operation still completes and the `ack` is still issued. Requesters must not drop `req` early; this behaviour is defined only for robustness.
- Simultaneous `req` bits with `rr_ptr`=k: the lowest index ≥ k wins; if none, the lowest index < k wins.
- A requester holding `req` after its `ack` is eligible again at the next IDLE, after all others in round-robin order.

## Timing
- Reset values:
  - All `ru_*` controls 0, except `ru_reset`=1 in the first INIT cycle.
  - `ack`=0, `err`=0, `rd_data`=0.
  - `init_done`=0, `reconfig_active`=0.
  - `rr_ptr`=0; state INIT.
- Latency from `req` seen in IDLE to `ack` is 4 cycles plus the number of busy cycles: IDLE→ISSUE→SETTLE→WAIT(n)→DONE, where WAIT lasts at least 1 cycle.
- `ru_data_in`, `ru_param` and `ru_read_source` are stable from ISSUE through DONE.
- `reset` mid-operation aborts immediately. No `ack` is issued and `ru_reconfig` drops in the next cycle.
- Width rule: `ru_data_in` is `req_data` taken verbatim. Callers pre-shift boot addresses (`addr>>2`).

## Structure
- Shared package `ru_pkg` holds:
  - Parameter codes: `RU_P_CONFDONE`=3'b001, `RU_P_WDOG_EN`=3'b011, `RU_P_BOOTADDR`=3'b100, `RU_P_OSCINT`=3'b110, `RU_P_REASON`=3'b111.
  - Reason-bit indices (CRC error = bit 3).
  - The state enum.
  - The `HOLD` ceiling function.
- One sub-module, `rr_arbiter`: parameterised round-robin grant (`req`, `ptr` → one-hot `grant`, `valid`).

## Test plan
1. Reset with the model holding `busy`=1 for 5 cycles → `ru_reset` pulses for 1 cycle; `init_done` rises after `busy` falls.
2. Requester 1 writes param 3'b100 with data 22'h040000, busy=3 cycles → one `ru_write_param` pulse, `ru_data_in`=22'h040000, `ack[1]` at cycle 7, `err`=0.
3. Requester 0 reads param 3'b111 and the model returns 24'h00000B → `ack[0]` with `rd_data`=24'h00000B, `ru_read_param` pulsed once.
4. All three requesters request continuously → grant order 0,1,2,0,1,2 and no starvation.
5. `reconfig_req` during requester 2's WAIT, `CLK_MHZ`=125 → requester 2 is acked first, then `ru_reconfig` rises; `reconfig_active` is 1 for 33 cycles; LOCKED holds with later `req` never acked.
6. `busy` stuck high with `TIMEOUT`=16 → `ack` with `err`=1 after 16 WAIT cycles; `rd_data` unchanged. Mid-WAIT `reset` → no `ack` and state INIT.
